ex_issue_stage: RTL and testbench
=================================

EX_ISSUE_STAGE -- requirements
Module: ex_issue_stage

Interface
REQ-001 The module SHALL have one clock `clk_i`, rising edge, and reset `rst_i`, synchronous and active-high.
REQ-002 Ports SHALL be as follows; outputs not marked "comb" SHALL be registered.
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- valid_i  in  1  decode-stage instruction valid
- stall_i  in  1  hold stage contents
- flush_i  in  1  kill incoming/held instruction
- instr_i  in  32  raw instruction
- pc_i  in  32  instruction PC
- imm_i  in  32  sign-extended immediate from decoder
- rs1_data_i, rs2_data_i  in  32  register-file read data
- exmem_rd_i, memwb_rd_i  in  5  forwarding destination registers
- exmem_we_i, memwb_we_i  in  1  forwarding write enables
- exmem_res_i, memwb_res_i  in  32  forwarding results
- valid_o  out  1  stage holds a live instruction
- alu_a_o, alu_b_o  out  32  ALU operands
- alu_op_o  out  4  ALU operation code
- store_data_o  out  32  forwarded rs2 value
- rd_o  out  5  destination register
- rd_we_o  out  1  writeback enable
- mem_rd_o, mem_wr_o  out  1  load / store flags
- illegal_o  out  1  unsupported encoding
- load_use_o  out  1  comb; stall request to decode

Function
REQ-003 The module SHALL use ALU op codes ADD=0000, SUB=0001, SLL=0010, SLT=0011, SLTU=0100, XOR=0101, SRL=0110, SRA=0111, OR=1000, AND=1001, PASSB=1111.
REQ-004 For OP (0110011), funct3 SHALL map 000→ADD or SUB (funct7 0000000 / 0100000), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL or SRA (funct7 0000000 / 0100000), 110 OR, 111 AND; any other funct7 SHALL be illegal; a=rs1, b=rs2.
REQ-005 For OP-IMM (0010011), the mapping SHALL follow REQ-004 except that 000 is always ADD and 001 requires funct7=0; a=rs1, b=imm_i.
REQ-006 The remaining opcodes SHALL decode as:
- LUI: PASSB, b=imm_i
- AUIPC: ADD, a=pc_i, b=imm_i
- JAL/JALR: ADD, a=pc_i, b=32'd4
- LOAD: ADD, a=rs1, b=imm_i, mem_rd_o=1
- STORE: ADD, a=rs1, b=imm_i, mem_wr_o=1, rd_we_o=0
- BRANCH: SUB, a=rs1, b=rs2, rd_we_o=0
REQ-007 Any other opcode SHALL capture illegal_o=1, rd_we_o=0, mem_rd_o=0, mem_wr_o=0, alu_op_o=ADD.
REQ-008 rd_we_o SHALL be 0 whenever rd=x0.
REQ-009 Forwarding for each source SHALL take exmem_res_i if exmem_we_i, exmem_rd_i==rs and rs≠0; else memwb_res_i on the equivalent match; else register-file data. EX/MEM SHALL win when both match.
REQ-010 x0 SHALL never be forwarded and SHALL read as 0.
REQ-011 Capture latency SHALL be 1 cycle: inputs sampled at edge N appear on outputs after edge N.
REQ-012 stall_i=1 with flush_i=0 SHALL hold every registered output unchanged.
REQ-013 flush_i=1 SHALL, at the next edge, force valid_o, rd_we_o, mem_rd_o, mem_wr_o and illegal_o to 0, overriding stall_i; data outputs are don't-care.
REQ-014 valid_i=0 (no stall, no flush) SHALL capture a bubble with the same control zeros as REQ-013.
REQ-015 load_use_o SHALL equal valid_i & valid_o & mem_rd_o & rd_o≠0 & (rd_o==rs1 when rs1 is used | rd_o==rs2 when rs2 is used). rs1 is used by OP, OP-IMM, LOAD, STORE, BRANCH and JALR; rs2 by OP, STORE and BRANCH.
REQ-016 load_use_o SHALL NOT itself stall the stage; the external hazard unit SHALL drive stall_i/flush_i.

Reset
REQ-017 While rst_i=1 at an edge, all registered outputs SHALL become 0, and reset SHALL override stall_i and flush_i.
REQ-018 Reset deasserted mid-operation SHALL resume with a bubble: valid_o=0 until the first valid_i capture.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- SUB x3,x1,x2 with rs1=10, rs2=3, no forwarding → next cycle alu_op_o=0001, a=10, b=3, rd_o=3, rd_we_o=1.
- ADDI x5,x5,-1 with exmem_rd_i=5/exmem_res_i=7 and memwb_rd_i=5/memwb_res_i=9 → a=7 (EX/MEM priority), b=FFFFFFFF.
- ADD x0,x1,x2 with exmem_rd_i=0, exmem_we_i=1, exmem_res_i=55 and rs1_data_i=0 → a=0 (x0 not forwarded), rd_we_o=0.
- LW x4,0(x1) captured, then decode presents ADD x6,x4,x2 → load_use_o=1 combinationally; stall_i=1 holds outputs unchanged.
- stall_i=1 and flush_i=1 on the same edge → valid_o=0, rd_we_o=0; rst_i=1 with valid_i=1 → all outputs 0.
- opcode 1111111, or OP funct7=0000001 → illegal_o=1, rd_we_o=0, valid_o=1.

Source files
------------

// File: rtl/ex_issue_stage.sv
// Execute-issue stage: decodes the instruction coming from decode, selects
// forwarded operands, and registers ALU operands and control for the execute
// stage. It also raises a combinational load-use request back to decode.
module ex_issue_stage (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] imm_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    input  logic [4:0]  exmem_rd_i,
    input  logic [4:0]  memwb_rd_i,
    input  logic        exmem_we_i,
    input  logic        memwb_we_i,
    input  logic [31:0] exmem_res_i,
    input  logic [31:0] memwb_res_i,
    output logic        valid_o,
    output logic [31:0] alu_a_o,
    output logic [31:0] alu_b_o,
    output logic [3:0]  alu_op_o,
    output logic [31:0] store_data_o,
    output logic [4:0]  rd_o,
    output logic        rd_we_o,
    output logic        mem_rd_o,
    output logic        mem_wr_o,
    output logic        illegal_o,
    output logic        load_use_o
);

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_SLL   = 4'b0010,
        ALU_SLT   = 4'b0011,
        ALU_SLTU  = 4'b0100,
        ALU_XOR   = 4'b0101,
        ALU_SRL   = 4'b0110,
        ALU_SRA   = 4'b0111,
        ALU_OR    = 4'b1000,
        ALU_AND   = 4'b1001,
        ALU_PASSB = 4'b1111
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Instruction fields
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] funct7;

    assign opcode = instr_i[6:0];
    assign rd     = instr_i[11:7];
    assign funct3 = instr_i[14:12];
    assign rs1    = instr_i[19:15];
    assign rs2    = instr_i[24:20];
    assign funct7 = instr_i[31:25];

    // Operand forwarding: EX/MEM beats MEM/WB, x0 is never forwarded and reads 0.
    logic [31:0] rs1_fwd;
    logic [31:0] rs2_fwd;

    assign rs1_fwd = (rs1 == 5'd0)                           ? 32'd0       :
                     (exmem_we_i && (exmem_rd_i == rs1))     ? exmem_res_i :
                     (memwb_we_i && (memwb_rd_i == rs1))     ? memwb_res_i :
                                                               rs1_data_i;

    assign rs2_fwd = (rs2 == 5'd0)                           ? 32'd0       :
                     (exmem_we_i && (exmem_rd_i == rs2))     ? exmem_res_i :
                     (memwb_we_i && (memwb_rd_i == rs2))     ? memwb_res_i :
                                                               rs2_data_i;

    // Base ALU operation selected by funct3 for OP / OP-IMM.
    alu_op_e f3_op;

    always_comb begin
        case (funct3)
            3'b000:  f3_op = ALU_ADD;
            3'b001:  f3_op = ALU_SLL;
            3'b010:  f3_op = ALU_SLT;
            3'b011:  f3_op = ALU_SLTU;
            3'b100:  f3_op = ALU_XOR;
            3'b101:  f3_op = ALU_SRL;
            3'b110:  f3_op = ALU_OR;
            default: f3_op = ALU_AND;
        endcase
    end

    // Decoded (next-state) control and operands.
    alu_op_e     dec_op;
    logic [31:0] dec_a;
    logic [31:0] dec_b;
    logic        dec_we;
    logic        dec_mrd;
    logic        dec_mwr;
    logic        dec_ill;
    logic        uses_rs1;
    logic        uses_rs2;

    // Opcode decode into ALU op, operand sources and control flags.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        dec_op   = ALU_ADD;
        dec_a    = rs1_fwd;
        dec_b    = rs2_fwd;
        dec_we   = 1'b0;
        dec_mrd  = 1'b0;
        dec_mwr  = 1'b0;
        dec_ill  = 1'b0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;

        case (opcode)
            OPC_OP: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                dec_we   = 1'b1;
                dec_op   = f3_op;
                if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    dec_op = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    dec_op = ALU_SRA;
                end else if (funct7 != F7_BASE) begin
                    dec_ill = 1'b1;
                end
            end
            OPC_OPIMM: begin
                uses_rs1 = 1'b1;
                dec_we   = 1'b1;
                dec_b    = imm_i;
                dec_op   = f3_op;
                // Upper immediate bits are only an encoding field for shifts.
                if (funct3 == 3'b101) begin
                    if (funct7 == F7_ALT) begin
                        dec_op = ALU_SRA;
                    end else if (funct7 != F7_BASE) begin
                        dec_ill = 1'b1;
                    end
                end else if (funct3 == 3'b001 && funct7 != F7_BASE) begin
                    dec_ill = 1'b1;
                end
            end
            OPC_LUI: begin
                dec_we = 1'b1;
                dec_op = ALU_PASSB;
                dec_a  = 32'd0;
                dec_b  = imm_i;
            end
            OPC_AUIPC: begin
                dec_we = 1'b1;
                dec_a  = pc_i;
                dec_b  = imm_i;
            end
            OPC_JAL: begin
                dec_we = 1'b1;
                dec_a  = pc_i;
                dec_b  = 32'd4;
            end
            OPC_JALR: begin
                uses_rs1 = 1'b1;
                dec_we   = 1'b1;
                dec_a    = pc_i;
                dec_b    = 32'd4;
            end
            OPC_LOAD: begin
                uses_rs1 = 1'b1;
                dec_we   = 1'b1;
                dec_mrd  = 1'b1;
                dec_b    = imm_i;
            end
            OPC_STORE: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                dec_mwr  = 1'b1;
                dec_b    = imm_i;
            end
            OPC_BRANCH: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                dec_op   = ALU_SUB;
            end
            default: dec_ill = 1'b1;
        endcase

        // Unsupported encodings must not write or touch memory.
        if (dec_ill) begin
            dec_op  = ALU_ADD;
            dec_we  = 1'b0;
            dec_mrd = 1'b0;
            dec_mwr = 1'b0;
        end

        if (rd == 5'd0) begin
            dec_we = 1'b0;
        end
    end

    // Pipeline register: reset > flush > stall > capture (instruction or bubble).
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            // NOTE: data registers are cleared too because they are visible outputs.
            valid_o      <= 1'b0;
            alu_a_o      <= 32'd0;
            alu_b_o      <= 32'd0;
            alu_op_o     <= 4'd0;
            store_data_o <= 32'd0;
            rd_o         <= 5'd0;
            rd_we_o      <= 1'b0;
            mem_rd_o     <= 1'b0;
            mem_wr_o     <= 1'b0;
            illegal_o    <= 1'b0;
        end else if (flush_i) begin
            valid_o   <= 1'b0;
            rd_we_o   <= 1'b0;
            mem_rd_o  <= 1'b0;
            mem_wr_o  <= 1'b0;
            illegal_o <= 1'b0;
        end else if (!stall_i) begin
            valid_o      <= valid_i;
            rd_we_o      <= valid_i & dec_we;
            mem_rd_o     <= valid_i & dec_mrd;
            mem_wr_o     <= valid_i & dec_mwr;
            illegal_o    <= valid_i & dec_ill;
            alu_a_o      <= dec_a;
            alu_b_o      <= dec_b;
            alu_op_o     <= dec_op;
            store_data_o <= rs2_fwd;
            rd_o         <= rd;
        end
    end

    // Load-use hazard: the held load writes a register the incoming instruction reads.
    assign load_use_o = valid_i & valid_o & mem_rd_o & (rd_o != 5'd0) &
                        ((uses_rs1 & (rd_o == rs1)) | (uses_rs2 & (rd_o == rs2)));

endmodule

// File: tb/tb_ex_issue_stage.sv
// Bench for ex_issue_stage: directed scenarios with literal expectations, then
// randomized traffic compared against a behavioural model of the stage.
module tb_ex_issue_stage;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;

    logic        clk_i = 1'b0;
    logic        rst_i, valid_i, stall_i, flush_i;
    logic [31:0] instr_i, pc_i, imm_i, rs1_data_i, rs2_data_i;
    logic [4:0]  exmem_rd_i, memwb_rd_i;
    logic        exmem_we_i, memwb_we_i;
    logic [31:0] exmem_res_i, memwb_res_i;
    logic        valid_o, rd_we_o, mem_rd_o, mem_wr_o, illegal_o, load_use_o;
    logic [31:0] alu_a_o, alu_b_o, store_data_o;
    logic [3:0]  alu_op_o;
    logic [4:0]  rd_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    ex_issue_stage dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .stall_i(stall_i),
        .flush_i(flush_i), .instr_i(instr_i), .pc_i(pc_i), .imm_i(imm_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .exmem_rd_i(exmem_rd_i), .memwb_rd_i(memwb_rd_i),
        .exmem_we_i(exmem_we_i), .memwb_we_i(memwb_we_i),
        .exmem_res_i(exmem_res_i), .memwb_res_i(memwb_res_i),
        .valid_o(valid_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
        .alu_op_o(alu_op_o), .store_data_o(store_data_o), .rd_o(rd_o),
        .rd_we_o(rd_we_o), .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o),
        .illegal_o(illegal_o), .load_use_o(load_use_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] r2, logic [4:0] r1,
                                          logic [2:0] f3, logic [4:0] rd, logic [6:0] opc);
        return {f7, r2, r1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] r1, logic [2:0] f3,
                                          logic [4:0] rd, logic [6:0] opc);
        return {imm, r1, f3, rd, opc};
    endfunction

    // Expected stage contents; *_k flags mark fields whose value is defined.
    typedef struct {
        logic        valid, we, mrd, mwr, ill;
        logic [3:0]  op;
        logic [31:0] a, b, sd;
        logic [4:0]  rd;
        logic        op_k, a_k, b_k, sd_k, rd_k;
    } st_t;

    st_t st;

    function automatic logic [31:0] fwd(logic [4:0] rs, logic [31:0] rf);
        if (rs == 0) return 32'd0;
        if (exmem_we_i && exmem_rd_i == rs) return exmem_res_i;
        if (memwb_we_i && memwb_rd_i == rs) return memwb_res_i;
        return rf;
    endfunction

    function automatic st_t model_issue();
        st_t s;
        logic [3:0]  f3_tab [8];
        logic [6:0]  opc = instr_i[6:0];
        logic [2:0]  f3  = instr_i[14:12];
        logic [6:0]  f7  = instr_i[31:25];
        logic [31:0] fa  = fwd(instr_i[19:15], rs1_data_i);
        logic [31:0] fb  = fwd(instr_i[24:20], rs2_data_i);
        f3_tab = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        s = '{default: 0};
        s.valid = 1; s.rd = instr_i[11:7]; s.rd_k = 1; s.op_k = 1;
        case (opc)
            OP: begin
                s.a = fa; s.b = fb; s.sd = fb; s.a_k = 1; s.b_k = 1; s.sd_k = 1; s.we = 1;
                s.op = f3_tab[f3];
                if (f7 == 7'h20 && f3 == 0) s.op = 4'd1;
                else if (f7 == 7'h20 && f3 == 5) s.op = 4'd7;
                else if (f7 != 0) s.ill = 1;
            end
            OPIMM: begin
                s.a = fa; s.b = imm_i; s.a_k = 1; s.b_k = 1; s.we = 1;
                s.op = f3_tab[f3];
                if (f3 == 5 && f7 == 7'h20) s.op = 4'd7;
                else if ((f3 == 1 || f3 == 5) && f7 != 0) s.ill = 1;
            end
            LUI:   begin s.op = 4'hF; s.b = imm_i; s.b_k = 1; s.we = 1; end
            AUIPC: begin s.a = pc_i; s.b = imm_i; s.a_k = 1; s.b_k = 1; s.we = 1; end
            JAL, JALR: begin s.a = pc_i; s.b = 32'd4; s.a_k = 1; s.b_k = 1; s.we = 1; end
            LOAD:  begin s.a = fa; s.b = imm_i; s.a_k = 1; s.b_k = 1; s.we = 1; s.mrd = 1; end
            STORE: begin
                s.a = fa; s.b = imm_i; s.sd = fb; s.a_k = 1; s.b_k = 1; s.sd_k = 1; s.mwr = 1;
            end
            BRANCH: begin
                s.op = 4'd1; s.a = fa; s.b = fb; s.sd = fb; s.a_k = 1; s.b_k = 1; s.sd_k = 1;
            end
            default: s.ill = 1;
        endcase
        if (s.ill) begin
            s.we = 0; s.mrd = 0; s.mwr = 0; s.op = 4'd0;
            s.a_k = 0; s.b_k = 0; s.sd_k = 0; s.rd_k = 0;
            s.op_k = (opc != OP);
        end
        if (s.rd == 0) s.we = 0;
        return s;
    endfunction

    function automatic st_t bubble(st_t s);
        st_t r = s;
        r.valid = 0; r.we = 0; r.mrd = 0; r.mwr = 0; r.ill = 0;
        r.op_k = 0; r.a_k = 0; r.b_k = 0; r.sd_k = 0; r.rd_k = 0;
        return r;
    endfunction

    function automatic logic model_load_use();
        logic [6:0] opc = instr_i[6:0];
        logic u1 = (opc == OP || opc == OPIMM || opc == LOAD || opc == STORE ||
                    opc == BRANCH || opc == JALR);
        logic u2 = (opc == OP || opc == STORE || opc == BRANCH);
        return valid_i && st.valid && st.mrd && st.rd != 0 &&
               ((u1 && st.rd == instr_i[19:15]) || (u2 && st.rd == instr_i[24:20]));
    endfunction

    task automatic check_state();
        check("r_valid", valid_o, st.valid);
        check("r_rd_we", rd_we_o, st.we);
        check("r_mem_rd", mem_rd_o, st.mrd);
        check("r_mem_wr", mem_wr_o, st.mwr);
        check("r_illegal", illegal_o, st.ill);
        if (st.op_k) check("r_alu_op", alu_op_o, st.op);
        if (st.a_k)  check("r_alu_a", alu_a_o, st.a);
        if (st.b_k)  check("r_alu_b", alu_b_o, st.b);
        if (st.sd_k) check("r_store_data", store_data_o, st.sd);
        if (st.rd_k) check("r_rd", rd_o, st.rd);
    endtask

    initial begin
        logic [6:0] opc_tab [10];
        opc_tab = '{OP, OPIMM, LUI, AUIPC, JAL, JALR, LOAD, STORE, BRANCH, 7'h00};

        rst_i = 1; valid_i = 1; stall_i = 0; flush_i = 0;
        instr_i = enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3, OP);
        pc_i = 32'h1000; imm_i = 32'h5; rs1_data_i = 32'h11; rs2_data_i = 32'h22;
        exmem_rd_i = 0; memwb_rd_i = 0; exmem_we_i = 0; memwb_we_i = 0;
        exmem_res_i = 0; memwb_res_i = 0;

        // Reset with a valid instruction presented: everything reads 0.
        tick();
        check("rst_valid", valid_o, 0);   check("rst_a", alu_a_o, 0);
        check("rst_b", alu_b_o, 0);       check("rst_op", alu_op_o, 0);
        check("rst_sd", store_data_o, 0); check("rst_rd", rd_o, 0);
        check("rst_we", rd_we_o, 0);      check("rst_mrd", mem_rd_o, 0);
        check("rst_mwr", mem_wr_o, 0);    check("rst_ill", illegal_o, 0);
        rst_i = 0;

        // SUB x3,x1,x2
        rs1_data_i = 10; rs2_data_i = 3;
        tick();
        check("sub_op", alu_op_o, 4'b0001); check("sub_a", alu_a_o, 10);
        check("sub_b", alu_b_o, 3);         check("sub_rd", rd_o, 3);
        check("sub_we", rd_we_o, 1);        check("sub_valid", valid_o, 1);

        // ADDI x5,x5,-1 with both forwarding paths matching
        instr_i = enc_i(12'hfff, 5'd5, 3'd0, 5'd5, OPIMM); imm_i = 32'hFFFF_FFFF;
        rs1_data_i = 100;
        exmem_we_i = 1; exmem_rd_i = 5; exmem_res_i = 7;
        memwb_we_i = 1; memwb_rd_i = 5; memwb_res_i = 9;
        tick();
        check("addi_a_exmem", alu_a_o, 7); check("addi_b", alu_b_o, 32'hFFFF_FFFF);
        check("addi_op", alu_op_o, 0);
        exmem_we_i = 0;
        tick();
        check("addi_a_memwb", alu_a_o, 9);

        // ADD x0,x1,x2 with EX/MEM claiming x0
        instr_i = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd0, OP);
        exmem_we_i = 1; exmem_rd_i = 0; exmem_res_i = 55; memwb_we_i = 0;
        rs1_data_i = 0; rs2_data_i = 8;
        tick();
        check("x0dst_a", alu_a_o, 0); check("x0dst_we", rd_we_o, 0);
        check("x0dst_valid", valid_o, 1);
        // ADD x7,x0,x2: x0 source reads 0 even with nonzero RF data
        instr_i = enc_r(7'h00, 5'd2, 5'd0, 3'd0, 5'd7, OP); rs1_data_i = 123;
        tick();
        check("x0src_a", alu_a_o, 0); check("x0src_b", alu_b_o, 8);

        // LW x4,0(x1) then dependent ADD x6,x4,x2
        exmem_we_i = 0;
        instr_i = enc_i(12'h000, 5'd1, 3'b010, 5'd4, LOAD); imm_i = 0; rs1_data_i = 32'h100;
        tick();
        check("lw_mrd", mem_rd_o, 1); check("lw_rd", rd_o, 4); check("lw_we", rd_we_o, 1);
        instr_i = enc_r(7'h00, 5'd2, 5'd4, 3'd0, 5'd6, OP);
        #1;
        check("lu_dep", load_use_o, 1);
        stall_i = 1;
        tick();
        check("stall_valid", valid_o, 1); check("stall_mrd", mem_rd_o, 1);
        check("stall_rd", rd_o, 4);       check("stall_a", alu_a_o, 32'h100);
        check("stall_b", alu_b_o, 0);     check("stall_op", alu_op_o, 0);
        check("stall_we", rd_we_o, 1);    check("stall_lu", load_use_o, 1);
        instr_i = enc_r(7'h00, 5'd2, 5'd5, 3'd0, 5'd6, OP);
        #1;
        check("lu_indep", load_use_o, 0);

        // Flush wins over stall
        flush_i = 1;
        tick();
        check("flush_valid", valid_o, 0); check("flush_we", rd_we_o, 0);
        check("flush_mrd", mem_rd_o, 0);
        stall_i = 0; flush_i = 0;

        // Illegal encodings
        instr_i = enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd5, 7'h7F);
        tick();
        check("ill_opc", illegal_o, 1); check("ill_opc_we", rd_we_o, 0);
        check("ill_opc_valid", valid_o, 1); check("ill_opc_op", alu_op_o, 0);
        check("ill_opc_mrd", mem_rd_o, 0); check("ill_opc_mwr", mem_wr_o, 0);
        instr_i = enc_r(7'h01, 5'd2, 5'd1, 3'd0, 5'd3, OP);
        tick();
        check("ill_f7", illegal_o, 1); check("ill_f7_we", rd_we_o, 0);
        check("ill_f7_valid", valid_o, 1);

        // Bubble
        valid_i = 0;
        tick();
        check("bubble_valid", valid_o, 0); check("bubble_ill", illegal_o, 0);

        // Randomized phase against the model, starting from reset.
        rst_i = 1;
        @(posedge clk_i);
        st = '{default: 0};
        #1;
        check_state();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [6:0] opc;
            rst_i   = ($urandom_range(99) < 2);
            valid_i = ($urandom_range(99) < 80);
            stall_i = ($urandom_range(99) < 20);
            flush_i = ($urandom_range(99) < 8);
            opc = opc_tab[$urandom_range(9)];
            if (opc == 7'h00) opc = 7'($urandom);
            case ($urandom_range(3))
                0:       instr_i[31:25] = 7'h00;
                1:       instr_i[31:25] = 7'h20;
                2:       instr_i[31:25] = 7'h00;
                default: instr_i[31:25] = 7'($urandom);
            endcase
            instr_i[24:20] = 5'($urandom_range(7));
            instr_i[19:15] = 5'($urandom_range(7));
            instr_i[14:12] = 3'($urandom);
            instr_i[11:7]  = 5'($urandom_range(7));
            instr_i[6:0]   = opc;
            pc_i = $urandom; imm_i = $urandom;
            rs1_data_i = $urandom; rs2_data_i = $urandom;
            exmem_we_i = 1'($urandom); exmem_rd_i = 5'($urandom_range(7));
            memwb_we_i = 1'($urandom); memwb_rd_i = 5'($urandom_range(7));
            exmem_res_i = $urandom; memwb_res_i = $urandom;
            #1;
            check("load_use", load_use_o, model_load_use());
            @(posedge clk_i);
            if (rst_i)          st = '{default: 0};
            else if (flush_i)   st = bubble(st);
            else if (!stall_i)  st = valid_i ? model_issue() : bubble(st);
            #1;
            check_state();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
